// File: rtl/simplepiano_pkg.sv
// Shared constants for the simple piano: default sizing, per-note divider table
// and small index helpers used by the voice allocator and the tone_gen wiring.
package simplepiano_pkg;

  localparam int DEF_NUM_KEYS      = 8;
  localparam int DEF_NUM_VOICES    = 2;
  localparam int DEF_WIDTH_COUNTER = 10;

  // Index width that stays at least one bit for single-entry vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int KEY_IDX_W = idx_w(DEF_NUM_KEYS);
  localparam int NUM_NOTES = 8;

  typedef logic [DEF_WIDTH_COUNTER-1:0] div_t;

  localparam div_t NOTE_DIV [NUM_NOTES] = '{
    10'd42, 10'd37, 10'd33, 10'd31, 10'd28, 10'd25, 10'd22, 10'd21
  };

  function automatic div_t note_div(input logic [KEY_IDX_W-1:0] key);
    return NOTE_DIV[key];
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Key inputs and per-voice tone_gen controls, flattened with voice v at slice v.
interface voice_allocator_if
  import simplepiano_pkg::*;
#(
  parameter int NUM_KEYS      = DEF_NUM_KEYS,
  parameter int NUM_VOICES    = DEF_NUM_VOICES,
  parameter int WIDTH_COUNTER = DEF_WIDTH_COUNTER
);

  localparam int KW = idx_w(NUM_KEYS);

  logic [NUM_KEYS-1:0]                 keys;
  logic [NUM_VOICES-1:0]               voice_active;
  logic [NUM_VOICES*KW-1:0]            voice_key;
  logic [NUM_VOICES*WIDTH_COUNTER-1:0] voice_div;

  modport master (
    output keys,
    input  voice_active, voice_key, voice_div
  );

  modport slave (
    input  keys,
    output voice_active, voice_key, voice_div
  );

endinterface

// File: rtl/voice_allocator_prio_enc.sv
// Lowest-index-first priority encoder; used for key selection and free-voice search.
module prio_enc
  import simplepiano_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic                 valid,
  output logic [idx_w(N)-1:0]  idx
);

  localparam int IW = idx_w(N);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic scheduler: one key allocation per cycle onto NUM_VOICES tone_gens,
// releases first, then a free voice, else round-robin steal.
module voice_allocator
  import simplepiano_pkg::*;
#(
  parameter int NUM_KEYS      = DEF_NUM_KEYS,
  parameter int NUM_VOICES    = DEF_NUM_VOICES,
  parameter int WIDTH_COUNTER = DEF_WIDTH_COUNTER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  voice_allocator_if.slave  bus
);

  localparam int KW = idx_w(NUM_KEYS);
  localparam int VW = idx_w(NUM_VOICES);

  logic [NUM_KEYS-1:0]      keys_q, keys_d;
  logic [NUM_KEYS-1:0]      keys_prev_q, keys_prev_d;
  logic [NUM_KEYS-1:0]      pend_q, pend_d;
  logic [NUM_VOICES-1:0]    active_q, active_d;
  logic [KW-1:0]            voice_key_q [NUM_VOICES];
  logic [KW-1:0]            voice_key_d [NUM_VOICES];
  logic [WIDTH_COUNTER-1:0] voice_div_q [NUM_VOICES];
  logic [WIDTH_COUNTER-1:0] voice_div_d [NUM_VOICES];
  logic [VW-1:0]            steal_ptr_q, steal_ptr_d;

  logic [NUM_KEYS-1:0]   new_press;
  logic [NUM_KEYS-1:0]   cand;
  logic [NUM_VOICES-1:0] releasing;
  logic [NUM_VOICES-1:0] held;
  logic [NUM_VOICES-1:0] free;
  logic                  key_valid;
  logic [KW-1:0]         key_sel;
  logic                  free_valid;
  logic [VW-1:0]         free_sel;
  logic                  owned;
  logic [VW-1:0]         target;

  logic [NUM_VOICES*KW-1:0]            key_flat;
  logic [NUM_VOICES*WIDTH_COUNTER-1:0] div_flat;

  prio_enc #(.N(NUM_KEYS)) u_key_enc (
    .req   (cand),
    .valid (key_valid),
    .idx   (key_sel)
  );

  prio_enc #(.N(NUM_VOICES)) u_voice_enc (
    .req   (free),
    .valid (free_valid),
    .idx   (free_sel)
  );

  // A voice whose key is no longer held is free for this cycle's allocation.
  always_comb begin
    new_press = keys_q & ~keys_prev_q;
    cand      = (pend_q | new_press) & keys_q;
    releasing = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      releasing[v] = active_q[v] & ~keys_q[voice_key_q[v]];
    end
    held = active_q & ~releasing;
    free = ~held;
  end

  always_comb begin
    keys_d      = bus.keys;
    keys_prev_d = keys_q;
    pend_d      = cand;
    active_d    = held;
    voice_key_d = voice_key_q;
    voice_div_d = voice_div_q;
    steal_ptr_d = steal_ptr_q;

    owned = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (held[v] && (voice_key_q[v] == key_sel)) owned = 1'b1;
    end
    target = free_valid ? free_sel : steal_ptr_q;

    if (!ena) begin
      pend_d      = '0;
      active_d    = '0;
      steal_ptr_d = '0;
    end else if (key_valid) begin
      pend_d[key_sel] = 1'b0;
      // A repeat press on a still-sounding key is consumed without reallocating.
      if (!owned) begin
        active_d[target]    = 1'b1;
        voice_key_d[target] = key_sel;
        voice_div_d[target] = WIDTH_COUNTER'(note_div(KEY_IDX_W'(key_sel)));
        steal_ptr_d         = (target == VW'(NUM_VOICES - 1)) ? '0 : target + VW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_q      <= '0;
      keys_prev_q <= '0;
      pend_q      <= '0;
      active_q    <= '0;
      steal_ptr_q <= '0;
      // NOTE: the per-voice arrays are a handful of output registers, so they are reset like any flop.
      for (int v = 0; v < NUM_VOICES; v++) begin
        voice_key_q[v] <= '0;
        voice_div_q[v] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
      keys_q      <= keys_d;
      keys_prev_q <= keys_prev_d;
      pend_q      <= pend_d;
      active_q    <= active_d;
      steal_ptr_q <= steal_ptr_d;
      voice_key_q <= voice_key_d;
      voice_div_q <= voice_div_d;
    end
  end

  always_comb begin
    key_flat = '0;
    div_flat = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      key_flat[v*KW +: KW]                       = voice_key_q[v];
      div_flat[v*WIDTH_COUNTER +: WIDTH_COUNTER] = voice_div_q[v];
    end
  end

  assign bus.voice_active = active_q;
  assign bus.voice_key    = key_flat;
  assign bus.voice_div    = div_flat;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (8 keys, 2 voices): table of per-edge vectors
// followed by hand sequences for asynchronous reset mid-operation.
module tb_voice_allocator;

  logic clk;
  logic rst;
  logic ena;

  int n_checks;
  int n_pass;

  voice_allocator_if #(.NUM_KEYS(8), .NUM_VOICES(2), .WIDTH_COUNTER(10)) bus ();

  voice_allocator #(.NUM_KEYS(8), .NUM_VOICES(2), .WIDTH_COUNTER(10)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  keys;
    logic        ena;
    logic [1:0]  act;
    logic [5:0]  vkey;
    logic [19:0] vdiv;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] act,
                               input logic [5:0] vkey, input logic [19:0] vdiv);
    check({tag, "_active"}, 32'(bus.voice_active), 32'(act));
    check({tag, "_key"},    32'(bus.voice_key),    32'(vkey));
    check({tag, "_div"},    32'(bus.voice_div),    32'(vdiv));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // keys, ena, active, {key1,key0}, {div1,div0}
    vecs[0]  = '{8'h08, 1'b1, 2'b00, 6'd0,  20'd0};      // key 3 sampled
    vecs[1]  = '{8'h08, 1'b1, 2'b01, 6'd3,  20'd31};     // key 3 -> voice 0
    vecs[2]  = '{8'h28, 1'b1, 2'b01, 6'd3,  20'd31};
    vecs[3]  = '{8'h28, 1'b1, 2'b11, 6'd43, 20'd25631};  // key 5 -> voice 1
    vecs[4]  = '{8'h20, 1'b1, 2'b11, 6'd43, 20'd25631};  // release key 3
    vecs[5]  = '{8'h00, 1'b1, 2'b10, 6'd43, 20'd25631};  // voice 0 drops, release key 5
    vecs[6]  = '{8'h00, 1'b1, 2'b00, 6'd43, 20'd25631};  // voice 1 drops, key/div hold
    vecs[7]  = '{8'h45, 1'b1, 2'b00, 6'd43, 20'd25631};  // keys 0,2,6 together
    vecs[8]  = '{8'h45, 1'b1, 2'b01, 6'd40, 20'd25642};  // key 0 -> voice 0
    vecs[9]  = '{8'h45, 1'b1, 2'b11, 6'd16, 20'd33834};  // key 2 -> voice 1
    vecs[10] = '{8'h45, 1'b1, 2'b11, 6'd22, 20'd33814};  // key 6 steals voice 0
    vecs[11] = '{8'hC5, 1'b1, 2'b11, 6'd22, 20'd33814};  // key 7 pressed
    vecs[12] = '{8'hC5, 1'b1, 2'b11, 6'd62, 20'd21526};  // steal_ptr=1: key 7 -> voice 1
    vecs[13] = '{8'h00, 1'b1, 2'b11, 6'd62, 20'd21526};
    vecs[14] = '{8'h00, 1'b1, 2'b00, 6'd62, 20'd21526};
    vecs[15] = '{8'h12, 1'b1, 2'b00, 6'd62, 20'd21526};  // keys 1,4 together
    vecs[16] = '{8'h02, 1'b1, 2'b01, 6'd57, 20'd21541};  // key 1 -> voice 0, key 4 released
    vecs[17] = '{8'h02, 1'b1, 2'b01, 6'd57, 20'd21541};  // key 4 dropped
    vecs[18] = '{8'h02, 1'b1, 2'b01, 6'd57, 20'd21541};
    vecs[19] = '{8'h0A, 1'b1, 2'b01, 6'd57, 20'd21541};  // key 3 pressed
    vecs[20] = '{8'h0A, 1'b1, 2'b11, 6'd25, 20'd31781};  // key 3 -> voice 1
    vecs[21] = '{8'h0A, 1'b0, 2'b00, 6'd25, 20'd31781};  // ena low clears actives
    vecs[22] = '{8'h0A, 1'b1, 2'b00, 6'd25, 20'd31781};  // held keys stay silent
    vecs[23] = '{8'h0A, 1'b1, 2'b00, 6'd25, 20'd31781};
    vecs[24] = '{8'h02, 1'b1, 2'b00, 6'd25, 20'd31781};  // lift key 3
    vecs[25] = '{8'h0A, 1'b1, 2'b00, 6'd25, 20'd31781};  // re-press key 3
    vecs[26] = '{8'h0A, 1'b1, 2'b01, 6'd27, 20'd31775};  // key 3 -> voice 0
    vecs[27] = '{8'h2A, 1'b1, 2'b01, 6'd27, 20'd31775};  // key 5 pressed
    vecs[28] = '{8'h2A, 1'b1, 2'b11, 6'd43, 20'd25631};  // key 5 -> voice 1

    rst      = 1'b1;
    ena      = 1'b1;
    bus.keys = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 2'b00, 6'd0, 20'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.keys = vecs[i].keys;
      ena      = vecs[i].ena;
      @(posedge clk);
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].act, vecs[i].vkey, vecs[i].vdiv);
    end

    // Asynchronous reset while both voices sound; keys 1,3,5 stay held.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 2'b00, 6'd0, 20'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("post_rst_e1", 2'b00, 6'd0, 20'd0);
    @(posedge clk);
    #1;
    check_outputs("post_rst_e2", 2'b01, 6'd1, 20'd37);
    @(posedge clk);
    #1;
    check_outputs("post_rst_e3", 2'b11, 6'd25, 20'd31781);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
